// File: rtl/sym_vn_lut_pkg.sv
// Shared definitions for the symmetric VN IB-LUT: loader state encoding,
// entry-address sizing and the sign-symmetry fold.
package sym_vn_lut_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOAD = 1'b1
   } ld_state_t;

   // One y0 bit is absorbed by the fold, so a page holds 2**(2Q-1) entries.
   function automatic int calc_entry_w(input int quan_size);
      return 2 * quan_size - 1;
   endfunction

   function automatic int calc_entry_num(input int quan_size);
      return 1 << calc_entry_w(quan_size);
   endfunction

   // Negative y0 maps onto the mirrored entry: invert the magnitude bits by the sign.
   function automatic logic fold_bit(input logic b, input logic sign);
      return b ^ sign;
   endfunction

endpackage

// File: rtl/sym_vn_lut_mp_if.sv
// Read-channel and loader signals of sym_vn_lut_mp; master drives requests
// and load beats, slave is the LUT.
interface sym_vn_lut_mp_if #(
   parameter int QUAN_SIZE = 3,
   parameter int PORT_NUM  = 4,
   parameter int PAGE_NUM  = 2,
   parameter int PAGE_W    = $clog2(PAGE_NUM)
);
   logic                          pipe_en;
   logic [PORT_NUM-1:0]           in_valid;
   logic [PORT_NUM*QUAN_SIZE-1:0] y0_in;
   logic [PORT_NUM*QUAN_SIZE-1:0] y1_in;
   logic [PAGE_W-1:0]             rd_page;
   logic [PORT_NUM-1:0]           out_valid;
   logic [PORT_NUM*QUAN_SIZE-1:0] t_c;
   logic [PORT_NUM-1:0]           transpose_en;
   logic [PAGE_W-1:0]             rd_page_out;
   logic                          wr_start;
   logic [PAGE_W-1:0]             wr_page;
   logic                          wr_valid;
   logic [QUAN_SIZE-1:0]          wr_data;
   logic                          wr_busy;
   logic                          load_done;

   modport master (
      output pipe_en, in_valid, y0_in, y1_in, rd_page,
      output wr_start, wr_page, wr_valid, wr_data,
      input  out_valid, t_c, transpose_en, rd_page_out, wr_busy, load_done
   );

   modport slave (
      input  pipe_en, in_valid, y0_in, y1_in, rd_page,
      input  wr_start, wr_page, wr_valid, wr_data,
      output out_valid, t_c, transpose_en, rd_page_out, wr_busy, load_done
   );
endinterface

// File: rtl/sym_vn_lut_bank.sv
// Multi-page LUT storage: PORT_NUM combinational read ports sharing one page
// select, one synchronous write port. Contents are never reset.
module sym_vn_lut_bank
   import sym_vn_lut_pkg::*;
#(
   parameter int QUAN_SIZE = 3,
   parameter int PORT_NUM  = 4,
   parameter int PAGE_NUM  = 2,
   parameter int PAGE_W    = $clog2(PAGE_NUM),
   parameter int ENTRY_W   = calc_entry_w(QUAN_SIZE)
) (
   input  logic                          sys_clk,
   input  logic                          wr_en,
   input  logic [PAGE_W-1:0]             wr_page,
   input  logic [ENTRY_W-1:0]            wr_addr,
   input  logic [QUAN_SIZE-1:0]          wr_data,
   input  logic [PAGE_W-1:0]             rd_page,
   input  logic [PORT_NUM*ENTRY_W-1:0]   rd_addr,
   output logic [PORT_NUM*QUAN_SIZE-1:0] rd_data
);
   localparam int ENTRY_NUM = 1 << ENTRY_W;

   logic [QUAN_SIZE-1:0] mem [PAGE_NUM][ENTRY_NUM];

   always_ff @(posedge sys_clk) begin
      if (wr_en) begin
         mem[wr_page][wr_addr] <= wr_data;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < PORT_NUM; gi++) begin : g_rd
         assign rd_data[gi*QUAN_SIZE +: QUAN_SIZE] = mem[rd_page][rd_addr[gi*ENTRY_W +: ENTRY_W]];
      end
   endgenerate

endmodule

// File: rtl/sym_vn_lut_mp.sv
// Multi-port, multi-page symmetric VN IB-LUT: sign fold, two-stage stallable
// read pipeline, and a streaming page loader.
module sym_vn_lut_mp
   import sym_vn_lut_pkg::*;
#(
   parameter int QUAN_SIZE = 3,
   parameter int PORT_NUM  = 4,
   parameter int PAGE_NUM  = 2
) (
   input  logic              sys_clk,
   input  logic              rstn,
   sym_vn_lut_mp_if.slave    bus
);
   localparam int PAGE_W  = $clog2(PAGE_NUM);
   localparam int ENTRY_W = calc_entry_w(QUAN_SIZE);
   localparam logic [ENTRY_W-1:0] CNT_LAST = '1;

   logic [PORT_NUM*ENTRY_W-1:0]   fold_addr;
   logic [PORT_NUM-1:0]           fold_sign;
   logic [PORT_NUM*QUAN_SIZE-1:0] rd_data;

   logic [PORT_NUM*ENTRY_W-1:0]   s0_addr_reg;
   logic [PORT_NUM-1:0]           s0_sign_reg;
   logic [PORT_NUM-1:0]           s0_valid_reg;
   logic [PAGE_W-1:0]             s0_page_reg;
   logic [PORT_NUM*QUAN_SIZE-1:0] s1_data_reg;
   logic [PORT_NUM-1:0]           s1_sign_reg;
   logic [PORT_NUM-1:0]           s1_valid_reg;
   logic [PAGE_W-1:0]             s1_page_reg;

   ld_state_t          state_reg, state_next;
   logic [ENTRY_W-1:0] cnt_reg, cnt_next;
   logic [PAGE_W-1:0]  ld_page_reg, ld_page_next;
   logic               done_reg, done_next;
   logic               wr_en;

   // Entry address per channel is {y0f, y1f}; y0's MSB is the sign and is carried, not stored.
   genvar gi, gj;
   generate
      for (gi = 0; gi < PORT_NUM; gi++) begin : g_fold
         assign fold_sign[gi] = bus.y0_in[gi*QUAN_SIZE + QUAN_SIZE-1];
         for (gj = 0; gj < QUAN_SIZE; gj++) begin : g_y1
            assign fold_addr[gi*ENTRY_W + gj] = fold_bit(bus.y1_in[gi*QUAN_SIZE + gj], fold_sign[gi]);
         end
         for (gj = 0; gj < QUAN_SIZE-1; gj++) begin : g_y0
            assign fold_addr[gi*ENTRY_W + QUAN_SIZE + gj] = fold_bit(bus.y0_in[gi*QUAN_SIZE + gj], fold_sign[gi]);
         end
      end
   endgenerate

   sym_vn_lut_bank #(
      .QUAN_SIZE (QUAN_SIZE),
      .PORT_NUM  (PORT_NUM),
      .PAGE_NUM  (PAGE_NUM),
      .PAGE_W    (PAGE_W),
      .ENTRY_W   (ENTRY_W)
   ) u_bank (
      .sys_clk (sys_clk),
      .wr_en   (wr_en),
      .wr_page (ld_page_reg),
      .wr_addr (cnt_reg),
      .wr_data (bus.wr_data),
      .rd_page (s0_page_reg),
      .rd_addr (s0_addr_reg),
      .rd_data (rd_data)
   );

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         s0_addr_reg  <= '0;
         s0_sign_reg  <= '0;
         s0_valid_reg <= '0;
         s0_page_reg  <= '0;
         s1_data_reg  <= '0;
         s1_sign_reg  <= '0;
         s1_valid_reg <= '0;
         s1_page_reg  <= '0;
      end else if (bus.pipe_en) begin
         s0_addr_reg  <= fold_addr;
         s0_sign_reg  <= fold_sign;
         s0_valid_reg <= bus.in_valid;
         s0_page_reg  <= bus.rd_page;
         s1_data_reg  <= rd_data;
         s1_sign_reg  <= s0_sign_reg;
         s1_valid_reg <= s0_valid_reg;
         s1_page_reg  <= s0_page_reg;
      end
   end

   assign bus.out_valid    = s1_valid_reg;
   assign bus.t_c          = s1_data_reg;
   assign bus.transpose_en = s1_sign_reg;
   assign bus.rd_page_out  = s1_page_reg;

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         ld_page_reg <= '0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         ld_page_reg <= ld_page_next;
         done_reg    <= done_next;
      end
   end

   // The final beat leaves LOAD directly, so cnt parks at its last value until the next start.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      ld_page_next = ld_page_reg;
      done_next    = 1'b0;
      wr_en        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.wr_start) begin
               state_next   = LOAD;
               cnt_next     = '0;
               ld_page_next = bus.wr_page;
            end
         end
         LOAD: begin
            if (bus.wr_valid) begin
               wr_en = 1'b1;
               if (cnt_reg == CNT_LAST) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.wr_busy   = (state_reg == LOAD);
   assign bus.load_done = done_reg;

endmodule

// File: doc/sym_vn_lut_mp.md
# sym_vn_lut_mp

Parametrised, multi-port, multi-page symmetric 2-input variable-node IB-LUT with an on-chip streaming loader. It serves PORT_NUM VNU channels per cycle: it folds each (y0, y1) pair using the sign symmetry, reads a per-request-selected LUT page and returns the t_c message with its transpose flag through a valid-tagged, stallable 2-register pipeline. It sits between the VNU message inputs and the VNU adder tree. It replaces the fixed 4-port, 2-page, ungated LUT front-end.

## Interface
- QUAN_SIZE, 3, message width in bits; output width is also QUAN_SIZE.
- PORT_NUM, 4, number of independent read channels.
- PAGE_NUM, 2, number of LUT pages (iteration sets); power of 2, ≥2.
- PAGE_W, $clog2(PAGE_NUM), page select width.
- ENTRY_W, 2*QUAN_SIZE-1, per-page entry address width; ENTRY_NUM = 2**ENTRY_W.
- sys_clk  in  1  single clock for reads and writes.
- rstn  in  1  asynchronous active-low reset.
- pipe_en  in  1  global pipeline advance; low holds every pipeline register.
- in_valid  in  PORT_NUM  per-channel request valid.
- y0_in  in  PORT_NUM*QUAN_SIZE  channel p occupies bits [p*QUAN_SIZE +: QUAN_SIZE].
- y1_in  in  PORT_NUM*QUAN_SIZE  same packing as y0_in.
- rd_page  in  PAGE_W  page for all requests issued this cycle.
- out_valid  out  PORT_NUM  per-channel result valid.
- t_c  out  PORT_NUM*QUAN_SIZE  LUT result, same packing as y0_in.
- transpose_en  out  PORT_NUM  registered MSB of y0_in.
- rd_page_out  out  PAGE_W  rd_page aligned with the results.
- wr_start  in  1  starts a page load; accepted only in IDLE.
- wr_page  in  PAGE_W  target page, sampled with an accepted wr_start.
- wr_valid  in  1  one data beat.
- wr_data  in  QUAN_SIZE  entry value.
- wr_busy  out  1  loader is in LOAD.
- load_done  out  1  one-cycle pulse after the last entry is written.

## Operation
- Fold, per channel: s = y0[QUAN_SIZE-1].
  - y0f = s ? ~y0[QUAN_SIZE-2:0] : y0[QUAN_SIZE-2:0].
  - y1f = s ? ~y1 : y1.
  - Entry address = {y0f, y1f}.
- Stage 0 register captures {y0f, y1f, s, in_valid} per channel, plus rd_page.
- Stage 1 register captures mem[page][addr], the carried s, the valid bits and the page.
- The stage-1 register drives the outputs directly, with no further logic.
- All channels read the memory concurrently. The number of read ports equals PORT_NUM.
- Invalid channels still advance through the pipeline. Their t_c is don't-care and out_valid stays 0.
- Loader FSM:
  - IDLE: wr_start=1 latches wr_page, clears cnt to 0, moves to LOAD.
  - LOAD: each wr_valid beat writes wr_data to mem[page][cnt], then cnt++.
  - The beat at cnt==ENTRY_NUM-1 returns the FSM to IDLE and raises load_done on the next cycle.
  - wr_start during LOAD is ignored.
  - wr_valid in IDLE is ignored.
- The loader is independent of pipe_en.
- Memory contents are not reset. Reset aborts an in-progress load; that page holds partial data.

## Timing
- Reset values: out_valid=0, t_c=0, transpose_en=0, rd_page_out=0, wr_busy=0, load_done=0, FSM=IDLE, cnt=0, all pipeline registers 0.
- Latency: a request sampled at edge k (pipe_en=1) appears on the outputs after edge k+1 (2 register stages). Throughput is 1 request per channel per cycle.
- pipe_en=0 at an edge: no stage updates, outputs hold, and the new inputs are dropped.
- Read/write collision: a stage-1 read of the entry being written at the same edge returns the old value. The new value is visible from the next edge.
- wr_busy rises the edge after an accepted wr_start and falls the edge after the final beat.
- load_done is high for exactly the cycle after wr_busy falls.
- cnt wraps to 0 only via a new wr_start. It never overflows, because the last beat exits LOAD.

## Structure
- Shared header sym_vn_lut_pkg holds:
  - the fold function;
  - ENTRY_W and ENTRY_NUM derivation;
  - the loader state encoding (IDLE=0, LOAD=1).
- Sub-module sym_vn_lut_bank: PAGE_NUM×ENTRY_NUM×QUAN_SIZE register array with PORT_NUM combinational read ports and one synchronous write port. This top instantiates it once.

## Test plan
Unless stated, QUAN_SIZE=3, PORT_NUM=4, PAGE_NUM=2.
- Reset mid-load:
  - Assert rstn=0 at beat 10 of a page-1 load.
  - All outputs are 0 and wr_busy=0.
  - A new wr_start after reset is accepted.
- Load and read page 0:
  - Load mem[0][i]=i[2:0] for all 32 entries.
  - load_done pulses once, 1 cycle after beat 31.
  - Request y0=3'b001, y1=3'b110, channel 0.
  - After 2 edges: t_c=3'b110 (entry 14), transpose_en=0, out_valid=4'b0001.
- Symmetric fold:
  - With page 0 loaded, request y0=3'b101, y1=3'b010.
  - Address is 5'b10101 (21), so t_c=3'b101 and transpose_en=1.
- Multi-page:
  - Load page 1 with the inverted pattern.
  - Alternate rd_page 0/1 on back-to-back requests.
  - rd_page_out and t_c alternate correctly with no bubble.
- Stall:
  - Hold pipe_en=0 for 3 cycles with requests in flight.
  - Outputs are frozen, inputs offered while stalled are dropped, and in-flight results emerge in order after release.
- Collision and ignored starts:
  - Write entry 21 on the same edge it is read: the old value returns, and the next read returns the new value.
  - wr_start during LOAD leaves the page and cnt unchanged.
